// File: rtl/lpce_rx_front.sv
// LPCE receive front end: hunts for the sync head, deserialises the 145-bit
// payload, checks the duplicated bits and delivers good frames as 128-bit words.
module lpce_rx_front #(
   parameter logic [9:0]  SYNC_HEAD = 10'b1010101010,
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                 Rx_CLKi,
   input  logic                 Rx_RSTn,
   input  logic                 LPCE_DATi,
   output logic [127:0]         FRM_DATAo,
   output logic                 FRM_VALIDo,
   output logic                 FRM_ERRo,
   output logic [ERR_CNT_W-1:0] ERR_CNTo,
   output logic                 SYNC_LOCKo
);

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   localparam logic [7:0] LAST_BIT = 8'd144;

   state_t               state_q, state_d;
   logic [9:0]           hunt_q, hunt_d;
   logic [9:0]           hunt_shift;
   logic [144:0]         payload_q, payload_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [127:0]         data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 lock_q, lock_d;
   logic [127:0]         stripped;
   logic                 dup_ok;

   // r0 lands in payload_q[144], r144 in payload_q[0]. Byte k (0..15) holds its
   // data at [143-9k -: 8] and the LSB copy at [135-9k]; r0 is the extra head copy.
   always_comb begin
      stripped = '0;
      dup_ok   = (payload_q[144] == payload_q[143]);
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j < 8; j++) begin
            stripped[127 - 8*k - j] = payload_q[143 - 9*k - j];
         end
         if (payload_q[135 - 9*k] != payload_q[136 - 9*k]) begin
            dup_ok = 1'b0;
         end
      end
   end

   // NOTE: every variable gets its default first so no path through the case leaves
   // it unassigned; that keeps this block purely combinational with no latches.
   always_comb begin
      state_d    = state_q;
      hunt_d     = hunt_q;
      payload_d  = payload_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;
      hunt_shift = {hunt_q[8:0], LPCE_DATi};

      unique case (state_q)
         ST_HUNT: begin
            hunt_d = hunt_shift;
            if (hunt_shift == SYNC_HEAD) begin
               state_d = ST_RECV;
               hunt_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_RECV: begin
            payload_d = {payload_q[143:0], LPCE_DATi};
            cnt_d     = cnt_q + 8'd1;
            if (cnt_q == LAST_BIT) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            // The bit arriving here is already part of the inter-frame gap, so
            // keep it to allow a next frame after only two idle zeros.
            hunt_d  = hunt_shift;
            state_d = ST_HUNT;
            if (dup_ok) begin
               data_d  = stripped;
               valid_d = 1'b1;
            end else begin
               err_d = 1'b1;
               if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                  err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
               end
            end
         end
         default: state_d = ST_HUNT;
      endcase

      lock_d = (state_d != ST_HUNT);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order or other always blocks.
   always_ff @(posedge Rx_CLKi or negedge Rx_RSTn) begin
      if (!Rx_RSTn) begin
         state_q   <= ST_HUNT;
         hunt_q    <= '0;
         payload_q <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         lock_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hunt_q    <= hunt_d;
         payload_q <= payload_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         lock_q    <= lock_d;
      end
   end

   assign FRM_DATAo  = data_q;
   assign FRM_VALIDo = valid_q;
   assign FRM_ERRo   = err_q;
   assign ERR_CNTo   = err_cnt_q;
   assign SYNC_LOCKo = lock_q;

endmodule

// File: tb/tb_lpce_rx_front.sv
// Directed bench for lpce_rx_front: table of single frames plus hand-written
// sequences for back-to-back frames, mid-frame reset and counter saturation.
module tb_lpce_rx_front;

   logic         clk;
   logic         rst_n;
   logic         dat;

   logic [127:0] u1_data;
   logic         u1_valid, u1_err, u1_lock;
   logic [15:0]  u1_cnt;
   logic [127:0] u2_data;
   logic         u2_valid, u2_err, u2_lock;
   logic [1:0]   u2_cnt;

   lpce_rx_front u_dut (
      .Rx_CLKi    (clk),
      .Rx_RSTn    (rst_n),
      .LPCE_DATi  (dat),
      .FRM_DATAo  (u1_data),
      .FRM_VALIDo (u1_valid),
      .FRM_ERRo   (u1_err),
      .ERR_CNTo   (u1_cnt),
      .SYNC_LOCKo (u1_lock)
   );

   lpce_rx_front #(.ERR_CNT_W(2)) u_dut_w2 (
      .Rx_CLKi    (clk),
      .Rx_RSTn    (rst_n),
      .LPCE_DATi  (dat),
      .FRM_DATAo  (u2_data),
      .FRM_VALIDo (u2_valid),
      .FRM_ERRo   (u2_err),
      .ERR_CNTo   (u2_cnt),
      .SYNC_LOCKo (u2_lock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_cyc = 0;

   // Strobe log, sampled on the falling edge (cyc = rising edges so far).
   int           v_cyc[$];
   logic [127:0] v_data[$];
   int           e_cyc[$];
   logic [15:0]  e_cnt[$];
   logic [1:0]   e2_cnt[$];
   int           v2_n     = 0;
   int           both_n   = 0;
   int           lock_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u1_valid) begin
         v_cyc.push_back(cyc);
         v_data.push_back(u1_data);
      end
      if (u1_err) begin
         e_cyc.push_back(cyc);
         e_cnt.push_back(u1_cnt);
      end
      if (u1_valid && u1_err) both_n = both_n + 1;
      if (u1_lock) lock_cnt = lock_cnt + 1;
      if (u2_err) e2_cnt.push_back(u2_cnt);
      if (u2_valid) v2_n = v2_n + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [154:0] encode(input logic [127:0] d);
      logic [154:0] l;
      int p;
      l = '0;
      for (int i = 0; i < 10; i++) l[154 - i] = (i % 2 == 0);
      p = 10;
      l[154 - p] = d[127];
      p++;
      for (int m = 0; m < 16; m++) begin
         for (int j = 0; j < 8; j++) begin
            l[154 - p] = d[127 - 8*m - j];
            p++;
         end
         l[154 - p] = d[120 - 8*m];
         p++;
      end
      return l;
   endfunction

   // Line bit r (payload) sits at line index 10+r.
   function automatic logic [154:0] flip_r(input logic [154:0] l, input int r);
      logic [154:0] o;
      o = l;
      o[144 - r] = ~o[144 - r];
      return o;
   endfunction

   task automatic send_line(input logic [154:0] l);
      for (int i = 0; i < 155; i++) begin
         @(negedge clk);
         dat = l[154 - i];
         last_cyc = cyc;
      end
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         dat = 1'b0;
      end
   endtask

   task automatic clear_log();
      v_cyc.delete();
      v_data.delete();
      e_cyc.delete();
      e_cnt.delete();
      e2_cnt.delete();
      v2_n     = 0;
      lock_cnt = 0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      dat   = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_data", u1_data, 128'h0);
      check("rst_valid", 128'(u1_valid), 128'h0);
      check("rst_err", 128'(u1_err), 128'h0);
      check("rst_cnt", 128'(u1_cnt), 128'h0);
      check("rst_lock", 128'(u1_lock), 128'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      string        name;
      logic [127:0] data;
      int           flip;       // payload bit to corrupt, -1 for none
      bit           alt;        // payload replaced by raw alternating 1010...
      bit           exp_valid;
      logic [15:0]  exp_cnt;
      logic [127:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   logic [154:0] line;
   logic [127:0] f_a, f_b;

   initial begin
      vecs[0] = '{"good_0123", 128'h0123456789ABCDEF_FEDCBA9876543210, -1, 1'b0, 1'b1, 16'd0,
                  128'h0123456789ABCDEF_FEDCBA9876543210};
      vecs[1] = '{"bad_r9", 128'h0123456789ABCDEF_FEDCBA9876543210, 9, 1'b0, 1'b0, 16'd1,
                  128'h0123456789ABCDEF_FEDCBA9876543210};
      vecs[2] = '{"good_aa", {16{8'hAA}}, -1, 1'b0, 1'b1, 16'd1, {16{8'hAA}}};
      vecs[3] = '{"bad_alt_payload", 128'h0, -1, 1'b1, 1'b0, 16'd2, {16{8'hAA}}};
      vecs[4] = '{"data_bit_r50", 128'h0, 50, 1'b0, 1'b1, 16'd2,
                  128'h0000_0000_0008_0000_0000_0000_0000_0000};
      vecs[5] = '{"bad_r144", 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0, 144, 1'b0, 1'b0, 16'd3,
                  128'h0000_0000_0008_0000_0000_0000_0000_0000};
      vecs[6] = '{"bad_r0", {128{1'b1}}, 0, 1'b0, 1'b0, 16'd4,
                  128'h0000_0000_0008_0000_0000_0000_0000_0000};
      vecs[7] = '{"good_5a", {16{8'h5A}}, -1, 1'b0, 1'b1, 16'd4, {16{8'h5A}}};

      dat   = 1'b0;
      rst_n = 1'b0;
      #1;
      check("reset_data", u1_data, 128'h0);
      check("reset_valid", 128'(u1_valid), 128'h0);
      check("reset_err", 128'(u1_err), 128'h0);
      check("reset_cnt", 128'(u1_cnt), 128'h0);
      check("reset_lock", 128'(u1_lock), 128'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      send_zeros(5);

      for (int v = 0; v < 8; v++) begin
         clear_log();
         line = encode(vecs[v].data);
         if (vecs[v].flip >= 0) line = flip_r(line, vecs[v].flip);
         if (vecs[v].alt) begin
            for (int r = 0; r < 145; r++) line[144 - r] = (r % 2 == 0);
         end
         send_line(line);
         send_zeros(20);
         check({vecs[v].name, "_nvalid"}, 128'(v_cyc.size()), 128'(vecs[v].exp_valid ? 1 : 0));
         check({vecs[v].name, "_nerr"}, 128'(e_cyc.size()), 128'(vecs[v].exp_valid ? 0 : 1));
         if (v_cyc.size() > 0) begin
            check({vecs[v].name, "_vcyc"}, 128'(v_cyc[0]), 128'(last_cyc + 2));
            check({vecs[v].name, "_vdata"}, v_data[0], vecs[v].exp_data);
         end
         if (e_cyc.size() > 0) begin
            check({vecs[v].name, "_ecyc"}, 128'(e_cyc[0]), 128'(last_cyc + 2));
         end
         check({vecs[v].name, "_data"}, u1_data, vecs[v].exp_data);
         check({vecs[v].name, "_cnt"}, 128'(u1_cnt), 128'(vecs[v].exp_cnt));
         check({vecs[v].name, "_lock"}, 128'(lock_cnt), 128'd146);
      end

      // Back-to-back frames with the minimum two-zero gap.
      clear_log();
      f_a = {128{1'b1}};
      f_b = 128'h0;
      send_line(encode(f_a));
      send_zeros(2);
      send_line(encode(f_b));
      send_zeros(20);
      check("b2b_nvalid", 128'(v_cyc.size()), 128'd2);
      if (v_cyc.size() == 2) begin
         check("b2b_spacing", 128'(v_cyc[1] - v_cyc[0]), 128'd157);
         check("b2b_second_cyc", 128'(v_cyc[1]), 128'(last_cyc + 2));
         check("b2b_data0", v_data[0], f_a);
         check("b2b_data1", v_data[1], f_b);
      end
      check("b2b_nerr", 128'(e_cyc.size()), 128'd0);

      // Reset in the middle of a frame, then a clean frame.
      clear_log();
      line = encode(128'hFFFF_0000_1234_5678_9ABC_DEF0_0F0F_F0F0);
      for (int i = 0; i < 81; i++) begin
         @(negedge clk);
         dat = line[154 - i];
      end
      pulse_reset();
      send_zeros(20);
      check("midrst_nstrobe", 128'(v_cyc.size() + e_cyc.size()), 128'd0);
      f_a = 128'h0123456789ABCDEF_FEDCBA9876543210;
      send_line(encode(f_a));
      send_zeros(20);
      check("midrst_nvalid", 128'(v_cyc.size()), 128'd1);
      if (v_cyc.size() > 0) begin
         check("midrst_vcyc", 128'(v_cyc[0]), 128'(last_cyc + 2));
         check("midrst_vdata", v_data[0], f_a);
      end
      check("midrst_cnt", 128'(u1_cnt), 128'd0);

      // Narrow counter saturation.
      pulse_reset();
      send_zeros(5);
      clear_log();
      for (int n = 0; n < 5; n++) begin
         send_line(flip_r(encode(f_a), 9));
         send_zeros(20);
      end
      check("sat_nerr", 128'(e2_cnt.size()), 128'd5);
      check("sat_nvalid", 128'(v2_n), 128'd0);
      if (e2_cnt.size() == 5) begin
         check("sat_cnt1", 128'(e2_cnt[0]), 128'd1);
         check("sat_cnt2", 128'(e2_cnt[1]), 128'd2);
         check("sat_cnt3", 128'(e2_cnt[2]), 128'd3);
         check("sat_cnt4", 128'(e2_cnt[3]), 128'd3);
         check("sat_cnt5", 128'(e2_cnt[4]), 128'd3);
      end
      check("sat_data_held", u2_data, 128'h0);
      check("sat_lock_idle", 128'(u2_lock), 128'h0);
      check("wide_cnt_5", 128'(u1_cnt), 128'd5);

      check("never_both", 128'(both_n), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
